// File: rtl/pmod_enc_if.sv
// Command handshake for the Pmod encoder emulator: a valid/ready transfer of
// one rotation command {dir, count}.
interface pmod_enc_if;
  logic       valid;
  logic       ready;
  logic       dir;
  logic [7:0] count;

  modport master (output valid, output dir, output count, input ready);
  modport slave  (input valid, input dir, input count, output ready);
endinterface

// File: rtl/pmod_enc_emu.sv
// Pmod rotary encoder emulator: queues {dir,count} rotation commands and plays them
// out as glitch-free quadrature on A/B, alongside registered button/switch levels.
module pmod_enc_emu #(
  parameter int PHASE_CYCLES = 1000,
  parameter int GAP_CYCLES   = 5000,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic           clk,
  input  logic           rst,
  pmod_enc_if.slave      cmd,
  input  logic           btn_in,
  input  logic           sw_in,
  output logic [3:0]     enc_out,
  output logic           busy,
  output logic           done,
  output logic [2:0]     level
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int LW   = AW + 1;
  localparam int TMAX = (PHASE_CYCLES > GAP_CYCLES) ? PHASE_CYCLES : GAP_CYCLES;
  localparam int TW   = $clog2(TMAX);
  localparam logic [TW-1:0] PHASE_LOAD = TW'(PHASE_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LOAD   = TW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LOAD, STEP, GAP} state_t;

  logic [8:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [LW-1:0] fill_reg;
  logic          push, pop;
  logic [8:0]    head;

  state_t        state_reg, state_next;
  logic [TW-1:0] tmr_reg, tmr_next;
  logic [7:0]    count_reg, count_next;
  logic          dir_reg, dir_next;
  logic [1:0]    phase_reg, phase_next;
  logic [1:0]    ab_reg, ab_next;       // {A, B}
  logic          done_reg, done_next;
  logic          btn_reg, sw_reg;

  // Gray position within one detent; phase 0 is the 11 rest state.
  function automatic logic [1:0] quad_ab(input logic cw, input logic [1:0] ph);
    logic [1:0] r;
    case (ph)
      2'd0:    r = 2'b11;
      2'd1:    r = cw ? 2'b01 : 2'b10;
      2'd2:    r = 2'b00;
      default: r = cw ? 2'b10 : 2'b01;
    endcase
    return r;
  endfunction

  assign cmd.ready = (fill_reg != LW'(FIFO_DEPTH));
  assign push      = cmd.valid & cmd.ready;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= {cmd.dir, cmd.count};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      fill_reg   <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   fill_reg <= fill_reg + 1'b1;
        2'b01:   fill_reg <= fill_reg - 1'b1;
        default: fill_reg <= fill_reg;
      endcase
    end
  end

  always_comb begin
    state_next = state_reg;
    tmr_next   = tmr_reg;
    count_next = count_reg;
    dir_next   = dir_reg;
    phase_next = phase_reg;
    ab_next    = ab_reg;
    done_next  = 1'b0;
    pop        = 1'b0;
    head       = mem[rd_ptr_reg];
    case (state_reg)
      IDLE: if (fill_reg != '0) state_next = LOAD;
      LOAD: begin
        pop        = 1'b1;
        dir_next   = head[8];
        count_next = head[7:0];
        phase_next = 2'd0;
        ab_next    = 2'b11;
        if (head[7:0] == 8'd0) begin
          state_next = GAP;
          tmr_next   = GAP_LOAD;
        end else begin
          state_next = STEP;
          tmr_next   = PHASE_LOAD;
        end
      end
      STEP: begin
        if (tmr_reg != '0) begin
          tmr_next = tmr_reg - 1'b1;
        end else begin
          tmr_next   = PHASE_LOAD;
          phase_next = phase_reg + 2'd1;
          ab_next    = quad_ab(dir_reg, phase_reg + 2'd1);
          // Fourth advance lands back on 11: one detent finished.
          if (phase_reg == 2'd3) begin
            count_next = count_reg - 8'd1;
            if (count_reg == 8'd1) begin
              state_next = GAP;
              tmr_next   = GAP_LOAD;
            end
          end
        end
      end
      GAP: begin
        ab_next = 2'b11;
        if (tmr_reg != '0) begin
          tmr_next = tmr_reg - 1'b1;
        end else begin
          done_next  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      tmr_reg   <= '0;
      count_reg <= '0;
      dir_reg   <= 1'b0;
      phase_reg <= 2'd0;
      ab_reg    <= 2'b11;
      done_reg  <= 1'b0;
      btn_reg   <= 1'b0;
      sw_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      tmr_reg   <= tmr_next;
      count_reg <= count_next;
      dir_reg   <= dir_next;
      phase_reg <= phase_next;
      ab_reg    <= ab_next;
      done_reg  <= done_next;
      btn_reg   <= btn_in;
      sw_reg    <= sw_in;
    end
  end

  assign enc_out = {sw_reg, btn_reg, ab_reg[0], ab_reg[1]};
  assign busy    = (state_reg != IDLE) || (fill_reg != '0);
  assign done    = done_reg;
  assign level   = 3'(fill_reg);

endmodule

// File: tb/tb_pmod_enc_emu.sv
// Directed bench for pmod_enc_emu with PHASE=4, GAP=8, depth 4; inputs driven and
// outputs sampled on the falling clock edge.
module tb_pmod_enc_emu;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_in = 1'b0;
  logic       sw_in = 1'b0;
  logic [3:0] enc_out;
  logic       busy, done;
  logic [2:0] level;
  int         checks = 0;
  int         errors = 0;

  pmod_enc_if cmd_if ();

  pmod_enc_emu #(.PHASE_CYCLES(4), .GAP_CYCLES(8), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .cmd(cmd_if), .btn_in(btn_in), .sw_in(sw_in),
    .enc_out(enc_out), .busy(busy), .done(done), .level(level)
  );

  always #5 clk = ~clk;

  // Expected {A,B} for a CW count=1 command accepted at edge 0, sampled after edge k.
  function automatic logic [1:0] cw1_ab(input int k);
    int j;
    if (k < 6) return 2'b11;
    j = (k - 6) / 4;
    case (j)
      0:       return 2'b01;
      1:       return 2'b00;
      2:       return 2'b10;
      default: return 2'b11;
    endcase
  endfunction

  function automatic logic [1:0] ab_of(input logic [3:0] e);
    return {e[0], e[1]};
  endfunction

  task automatic push_cmd(input logic d, input logic [7:0] n);
    cmd_if.valid = 1'b1;
    cmd_if.dir   = d;
    cmd_if.count = n;
    $display("push dir=%0d count=%0d", d, n);
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++; if (enc_out !== 4'b0011) begin errors++; $display("FAIL reset_enc got=%b exp=0011", enc_out); end
    checks++; if (cmd_if.ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", cmd_if.ready); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_busy_done got=%b%b exp=00", busy, done); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL reset_level got=%0d exp=0", level); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_cw;
    logic [1:0] got;
    checks++; if (cmd_if.ready !== 1'b1) begin errors++; $display("FAIL cw_ready got=%b exp=1", cmd_if.ready); end
    push_cmd(1'b1, 8'd1);
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (k == 0) cmd_if.valid = 1'b0;
      got = ab_of(enc_out);
      checks++; if (got !== cw1_ab(k)) begin errors++; $display("FAIL cw_ab k=%0d got=%b exp=%b", k, got, cw1_ab(k)); end
      checks++; if (done !== (k == 26)) begin errors++; $display("FAIL cw_done k=%0d got=%b exp=%b", k, done, (k == 26)); end
      if (k == 0) begin
        checks++; if (level !== 3'd1 || busy !== 1'b1) begin errors++; $display("FAIL cw_level0 got=%0d/%b exp=1/1", level, busy); end
      end
      if (k == 2) begin
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL cw_pop got=%0d exp=0", level); end
      end
      if (k == 26) begin
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cw_busy got=%b exp=0", busy); end
      end
    end
  endtask

  task automatic test_ccw;
    logic [1:0] prev, cur;
    int trans = 0, pos = 0, dones = 0, dk = -1;
    prev = 2'b11;
    push_cmd(1'b0, 8'd3);
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (k == 0) cmd_if.valid = 1'b0;
      cur = ab_of(enc_out);
      if (cur != prev) begin
        trans++;
        checks++; if ($countones(cur ^ prev) != 1) begin errors++; $display("FAIL ccw_gray k=%0d got=%b from=%b", k, cur, prev); end
        if (trans == 1) begin
          checks++; if (cur !== 2'b10) begin errors++; $display("FAIL ccw_first got=%b exp=10", cur); end
        end
        if (cur == 2'b11 && prev == 2'b10) pos = (pos + 1) % 160;
        if (cur == 2'b11 && prev == 2'b01) pos = (pos + 159) % 160;
        prev = cur;
      end
      if (done) begin dones++; dk = k; end
    end
    checks++; if (trans != 12) begin errors++; $display("FAIL ccw_trans got=%0d exp=12", trans); end
    checks++; if (pos != 157) begin errors++; $display("FAIL ccw_pos got=%0d exp=157", pos); end
    checks++; if (dones != 1 || dk != 58) begin errors++; $display("FAIL ccw_done got=%0d@%0d exp=1@58", dones, dk); end
  endtask

  task automatic test_queue;
    int acc = 0, i5 = -1, i6 = -1, dones = 0, drained = 0;
    push_cmd(1'b1, 8'd1);
    for (int i = 0; i < 60 && acc < 6; i++) begin
      if (cmd_if.ready) begin
        acc++;
        $display("accept #%0d at cycle %0d", acc, i);
        if (acc == 5) i5 = i;
        if (acc == 6) i6 = i;
      end
      if (i == 5) begin
        checks++; if (level !== 3'd4 || cmd_if.ready !== 1'b0) begin errors++; $display("FAIL queue_full got=%0d/%b exp=4/0", level, cmd_if.ready); end
      end
      @(negedge clk);
      if (done) dones++;
    end
    cmd_if.valid = 1'b0;
    checks++; if (i5 != 4 || i6 != 29) begin errors++; $display("FAIL queue_accept got=%0d,%0d exp=4,29", i5, i6); end
    for (int k = 0; k < 400 && drained == 0; k++) begin
      if (busy == 1'b0) drained = 1;
      else begin
        @(negedge clk);
        if (done) dones++;
      end
    end
    checks++; if (drained != 1) begin errors++; $display("FAIL queue_drain got=busy exp=idle"); end
    checks++; if (dones != 6) begin errors++; $display("FAIL queue_dones got=%0d exp=6", dones); end
  endtask

  task automatic test_zero;
    push_cmd(1'b1, 8'd0);
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (k == 0) cmd_if.valid = 1'b0;
      checks++; if (ab_of(enc_out) !== 2'b11) begin errors++; $display("FAIL zero_ab k=%0d got=%b exp=11", k, ab_of(enc_out)); end
      checks++; if (done !== (k == 10)) begin errors++; $display("FAIL zero_done k=%0d got=%b exp=%b", k, done, (k == 10)); end
    end
  endtask

  task automatic test_reset_mid;
    int spur = 0;
    push_cmd(1'b1, 8'd1);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k == 0) cmd_if.valid = 1'b0;
      if (k == 5) push_cmd(1'b0, 8'd2);
      if (k == 6) cmd_if.valid = 1'b0;
    end
    checks++; if (ab_of(enc_out) !== 2'b00 || level !== 3'd1) begin errors++; $display("FAIL rst_pre got=%b/%0d exp=00/1", ab_of(enc_out), level); end
    rst = 1'b1;
    #1;
    checks++; if (enc_out !== 4'b0011) begin errors++; $display("FAIL rst_enc got=%b exp=0011", enc_out); end
    checks++; if (level !== 3'd0 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rst_state got=%0d/%b/%b exp=0/0/0", level, busy, done); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (done) spur++;
    end
    checks++; if (spur != 0) begin errors++; $display("FAIL rst_nodone got=%0d exp=0", spur); end
    push_cmd(1'b1, 8'd1);
    for (int k = 0; k < 28; k++) begin
      @(negedge clk);
      if (k == 0) cmd_if.valid = 1'b0;
      if (k == 5 || k == 6 || k == 18) begin
        checks++; if (ab_of(enc_out) !== cw1_ab(k)) begin errors++; $display("FAIL rst_rerun_ab k=%0d got=%b exp=%b", k, ab_of(enc_out), cw1_ab(k)); end
      end
      checks++; if (done !== (k == 26)) begin errors++; $display("FAIL rst_rerun_done k=%0d got=%b exp=%b", k, done, (k == 26)); end
    end
  endtask

  task automatic test_btn_sw;
    logic exp_btn, exp_sw;
    exp_btn = btn_in;
    exp_sw  = sw_in;
    push_cmd(1'b1, 8'd1);
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (k == 0) cmd_if.valid = 1'b0;
      checks++; if (enc_out[2] !== exp_btn || enc_out[3] !== exp_sw) begin errors++; $display("FAIL btnsw k=%0d got=%b%b exp=%b%b", k, enc_out[3], enc_out[2], exp_sw, exp_btn); end
      checks++; if (ab_of(enc_out) !== cw1_ab(k)) begin errors++; $display("FAIL btnsw_ab k=%0d got=%b exp=%b", k, ab_of(enc_out), cw1_ab(k)); end
      btn_in  = (k >= 7 && k < 15);
      sw_in   = (k >= 11 && k < 20);
      exp_btn = btn_in;
      exp_sw  = sw_in;
    end
  endtask

  initial begin
    cmd_if.valid = 1'b0;
    cmd_if.dir   = 1'b0;
    cmd_if.count = 8'd0;
    test_reset();
    test_cw();
    test_ccw();
    test_queue();
    test_zero();
    test_reset_mid();
    test_btn_sw();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
